// File: rtl/lc3b_bpred_pkg.sv
// Shared LC-3b branch-prediction types: prediction bits, PHT counter type/encodings
// and the saturating counter step used by lc3b_bpred.
package lc3b_types;

  typedef struct packed {
    logic btb_hit;
    logic pht_taken;
  } lc3b_brp_bits;

  typedef logic [1:0] lc3b_pht_ctr;

  localparam lc3b_pht_ctr PHT_SNT = 2'b00;
  localparam lc3b_pht_ctr PHT_WNT = 2'b01;
  localparam lc3b_pht_ctr PHT_WT  = 2'b10;
  localparam lc3b_pht_ctr PHT_ST  = 2'b11;

  localparam int unsigned PC_W = 16;

  function automatic lc3b_pht_ctr pht_next(input lc3b_pht_ctr ctr, input logic taken);
    lc3b_pht_ctr res;
    res = ctr;
    if (taken) begin
      if (ctr != PHT_ST) res = ctr + 2'd1;
    end else begin
      if (ctr != PHT_SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/lc3b_bpred_btb.sv
// Direct-mapped branch target buffer: combinational read, synchronous write,
// asynchronous clear of the valid bits. Ports take the word address pc[15:1].
module lc3b_btb #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] i_rd_pc,
  output logic        o_hit,
  output logic [15:0] o_target,
  input  logic        i_wr_en,
  input  logic [14:0] i_wr_pc,
  input  logic [15:0] i_wr_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 15 - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [15:0]        r_target [ENTRIES];

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;

  assign w_rd_idx = i_rd_pc[IDX_W-1:0];
  assign w_rd_tag = i_rd_pc[14:IDX_W];
  assign w_wr_idx = i_wr_pc[IDX_W-1:0];
  assign w_wr_tag = i_wr_pc[14:IDX_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[w_wr_idx]    <= w_wr_tag;
      r_target[w_wr_idx] <= i_wr_target;
    end
  end

  assign o_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_target = o_hit ? r_target[w_rd_idx] : 16'h0000;

endmodule

// File: rtl/lc3b_bpred.sv
// LC-3b branch predictor: BTB + 2-bit PHT, same-cycle prediction, resolve-stage training,
// mispredict detect and saturating stats. Define LC3B_BPRED_GSHARE_EN for gshare indexing.
module lc3b_bpred
  import lc3b_types::*;
#(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned PHT_ENTRIES = 64,
  parameter int unsigned GHR_BITS    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  fetch_pc,
  output lc3b_brp_bits pred_bits,
  output logic         pred_taken,
  output logic [15:0]  pred_target,
  input  logic         upd_valid,
  input  logic [15:0]  upd_pc,
  input  logic         upd_taken,
  input  logic [15:0]  upd_target,
  input  lc3b_brp_bits upd_brp,
  input  logic [15:0]  upd_pred_target,
  output logic         mispredict,
  output logic [15:0]  br_count,
  output logic [15:0]  mp_count
);

  localparam int unsigned P = $clog2(PHT_ENTRIES);

  lc3b_pht_ctr r_pht [PHT_ENTRIES];
  logic [15:0] r_br_count;
  logic [15:0] r_mp_count;

  logic [P-1:0] w_fetch_idx;
  logic [P-1:0] w_upd_idx;
  logic         w_btb_hit;
  logic         w_upd_pred_taken;
  logic [1:0]   w_unused_pc_lsb;

  assign w_unused_pc_lsb = {fetch_pc[0], upd_pc[0]};

`ifdef LC3B_BPRED_GSHARE_EN
  logic [GHR_BITS-1:0] r_ghr;

  // History is trained only by resolved branches; update index uses the pre-shift value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ghr <= '0;
    end else if (upd_valid) begin
      r_ghr <= GHR_BITS'({r_ghr, upd_taken});
    end
  end

  assign w_fetch_idx = fetch_pc[P:1] ^ P'(r_ghr);
  assign w_upd_idx   = upd_pc[P:1] ^ P'(r_ghr);
`else
  logic [31:0] w_unused_ghr_bits;
  assign w_unused_ghr_bits = 32'(GHR_BITS);

  assign w_fetch_idx = fetch_pc[P:1];
  assign w_upd_idx   = upd_pc[P:1];
`endif

  lc3b_btb #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (reset),
    .i_rd_pc     (fetch_pc[15:1]),
    .o_hit       (w_btb_hit),
    .o_target    (pred_target),
    .i_wr_en     (upd_valid & upd_taken),
    .i_wr_pc     (upd_pc[15:1]),
    .i_wr_target (upd_target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
        r_pht[i] <= PHT_WNT;
      end
    end else if (upd_valid) begin
      r_pht[w_upd_idx] <= pht_next(r_pht[w_upd_idx], upd_taken);
    end
  end

  assign pred_bits.btb_hit   = w_btb_hit;
  assign pred_bits.pht_taken = r_pht[w_fetch_idx][1];
  assign pred_taken          = w_btb_hit & r_pht[w_fetch_idx][1];

  // Redirect on direction error, or on a correctly predicted taken branch with a stale target.
  assign w_upd_pred_taken = upd_brp.btb_hit & upd_brp.pht_taken;
  assign mispredict = upd_valid &
                      ((w_upd_pred_taken != upd_taken) |
                       (upd_taken & w_upd_pred_taken & (upd_pred_target != upd_target)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_br_count <= 16'h0000;
      r_mp_count <= 16'h0000;
    end else begin
      if (upd_valid && (r_br_count != 16'hFFFF)) r_br_count <= r_br_count + 16'd1;
      if (mispredict && (r_mp_count != 16'hFFFF)) r_mp_count <= r_mp_count + 16'd1;
    end
  end

  assign br_count = r_br_count;
  assign mp_count = r_mp_count;

endmodule

// File: tb/tb_lc3b_bpred.sv
// Scoreboard bench for lc3b_bpred (default build): driver queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_lc3b_bpred;
  import lc3b_types::*;

  logic         clk;
  logic         reset;
  logic [15:0]  fetch_pc;
  lc3b_brp_bits pred_bits;
  logic         pred_taken;
  logic [15:0]  pred_target;
  logic         upd_valid;
  logic [15:0]  upd_pc;
  logic         upd_taken;
  logic [15:0]  upd_target;
  lc3b_brp_bits upd_brp;
  logic [15:0]  upd_pred_target;
  logic         mispredict;
  logic [15:0]  br_count;
  logic [15:0]  mp_count;

  lc3b_bpred dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_pc        (fetch_pc),
    .pred_bits       (pred_bits),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_brp         (upd_brp),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .br_count        (br_count),
    .mp_count        (mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int SEL_BITS = 0, SEL_TGT = 1, SEL_MP = 2, SEL_BRC = 3, SEL_MPC = 4, SEL_PT = 5;

  string       q_name [$];
  int          q_sel  [$];
  logic [15:0] q_exp  [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic expect_val(input string nm, input int sel, input logic [15:0] v);
    q_name.push_back(nm);
    q_sel.push_back(sel);
    q_exp.push_back(v);
  endtask

  function automatic logic [15:0] dut_val(input int sel);
    case (sel)
      SEL_BITS: return {14'd0, pred_bits};
      SEL_TGT:  return pred_target;
      SEL_MP:   return {15'd0, mispredict};
      SEL_BRC:  return br_count;
      SEL_MPC:  return mp_count;
      default:  return {15'd0, pred_taken};
    endcase
  endfunction

  // Monitor: compare every queued expectation against the DUT away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      while (q_sel.size() > 0) begin
        string       nm;
        int          sel;
        logic [15:0] e;
        logic [15:0] a;
        nm  = q_name.pop_front();
        sel = q_sel.pop_front();
        e   = q_exp.pop_front();
        a   = dut_val(sel);
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic [15:0] pc, input logic taken, input logic [15:0] tgt,
                           input logic [1:0] brp, input logic [15:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = taken;
    upd_target      = tgt;
    upd_brp         = brp;
    upd_pred_target = ptgt;
  endtask

  task automatic idle_upd();
    upd_valid = 1'b0;
    upd_taken = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    fetch_pc = 16'h3000;
    upd_valid = 1'b0; upd_pc = 16'h0; upd_taken = 1'b0; upd_target = 16'h0;
    upd_brp = 2'b00; upd_pred_target = 16'h0;
    #12 reset = 1'b0;
    step();

    // Reset state
    expect_val("rst_bits", SEL_BITS, 16'h0000);
    expect_val("rst_tgt",  SEL_TGT,  16'h0000);
    expect_val("rst_pt",   SEL_PT,   16'h0000);
    expect_val("rst_brc",  SEL_BRC,  16'h0000);
    expect_val("rst_mpc",  SEL_MPC,  16'h0000);

    // Training: cold taken branch mispredicts; prediction unchanged before the edge
    drive_upd(16'h3000, 1'b1, 16'h3040, 2'b00, 16'h0000);
    expect_val("train_mp",        SEL_MP,   16'h0001);
    expect_val("train_nobypass",  SEL_BITS, 16'h0000);
    step();
    idle_upd();
    expect_val("train_bits", SEL_BITS, 16'h0003);
    expect_val("train_tgt",  SEL_TGT,  16'h3040);
    expect_val("train_brc",  SEL_BRC,  16'h0001);
    expect_val("train_mpc",  SEL_MPC,  16'h0001);
    expect_val("train_idle_mp", SEL_MP, 16'h0000);
    step();

    // Saturation: four correct taken updates (WT->ST, held)
    for (int k = 0; k < 4; k++) begin
      drive_upd(16'h3000, 1'b1, 16'h3040, 2'b11, 16'h3040);
      expect_val("sat_taken_mp", SEL_MP, 16'h0000);
      step();
    end
    // Back-to-back not-taken: ST->WT->WNT
    drive_upd(16'h3000, 1'b0, 16'h3040, 2'b11, 16'h3040);
    expect_val("nt1_mp", SEL_MP, 16'h0001);
    step();
    drive_upd(16'h3000, 1'b0, 16'h3040, 2'b11, 16'h3040);
    expect_val("nt2_mp",   SEL_MP,   16'h0001);
    expect_val("hyst_bits", SEL_BITS, 16'h0003);
    expect_val("hyst_brc", SEL_BRC,  16'h0006);
    expect_val("hyst_mpc", SEL_MPC,  16'h0002);
    step();
    idle_upd();
    expect_val("wnt_bits", SEL_BITS, 16'h0002);
    expect_val("wnt_pt",   SEL_PT,   16'h0000);
    expect_val("wnt_tgt",  SEL_TGT,  16'h3040);
    expect_val("wnt_brc",  SEL_BRC,  16'h0007);
    expect_val("wnt_mpc",  SEL_MPC,  16'h0003);
    step();

    // Aliasing: 16'h3020 shares BTB index 0 with 16'h3000 but has another tag
    drive_upd(16'h3020, 1'b1, 16'h3100, 2'b00, 16'h0000);
    expect_val("alias_mp", SEL_MP, 16'h0001);
    step();
    idle_upd();
    expect_val("alias_old_bits", SEL_BITS, 16'h0000);
    expect_val("alias_old_tgt",  SEL_TGT,  16'h0000);
    step();
    fetch_pc = 16'h3020;
    expect_val("alias_new_bits", SEL_BITS, 16'h0003);
    expect_val("alias_new_tgt",  SEL_TGT,  16'h3100);
    expect_val("alias_brc",      SEL_BRC,  16'h0008);
    expect_val("alias_mpc",      SEL_MPC,  16'h0004);
    step();

    // Target mismatch on a correctly predicted taken branch
    drive_upd(16'h3020, 1'b1, 16'h3080, 2'b11, 16'h3040);
    expect_val("tmis_mp", SEL_MP, 16'h0001);
    step();
    // Correctly predicted not-taken with a BTB hit but weak counter
    drive_upd(16'h3040, 1'b0, 16'h0000, 2'b10, 16'h0000);
    expect_val("nt_ok_mp",  SEL_MP,   16'h0000);
    expect_val("tmis_bits", SEL_BITS, 16'h0003);
    expect_val("tmis_tgt",  SEL_TGT,  16'h3080);
    step();
    idle_upd();
    expect_val("mid_brc", SEL_BRC, 16'h000A);
    expect_val("mid_mpc", SEL_MPC, 16'h0005);
    step();

    // Asynchronous reset in the middle of a cycle with an update pending
    drive_upd(16'h3020, 1'b1, 16'h3200, 2'b00, 16'h0000);
    #1 reset = 1'b1;
    #1 idle_upd();
    #1 reset = 1'b0;
    expect_val("arst_bits", SEL_BITS, 16'h0000);
    expect_val("arst_tgt",  SEL_TGT,  16'h0000);
    expect_val("arst_brc",  SEL_BRC,  16'h0000);
    expect_val("arst_mpc",  SEL_MPC,  16'h0000);
    step();
    expect_val("arst_after_bits", SEL_BITS, 16'h0000);
    expect_val("arst_after_brc",  SEL_BRC,  16'h0000);
    step();

    // Counter saturation: 65535 correctly predicted not-taken updates reach 16'hFFFF
    drive_upd(16'h3100, 1'b0, 16'h0000, 2'b00, 16'h0000);
    repeat (65535) step();
    expect_val("sat_brc_ffff", SEL_BRC, 16'hFFFF);
    expect_val("sat_mp_none",  SEL_MP,  16'h0000);
    step();
    idle_upd();
    expect_val("sat_brc_hold", SEL_BRC, 16'hFFFF);
    expect_val("sat_mpc_zero", SEL_MPC, 16'h0000);
    step();
    step();

    if (q_sel.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q_sel.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3b_bpred.md
# lc3b_bpred

Parametrised branch predictor for the pipelined LC-3b core. It combines a direct-mapped branch target buffer (BTB) with a pattern history table (PHT) of 2-bit saturating counters. It gives the fetch stage a same-cycle prediction and takes non-speculative training from the resolving stage. It also reports mispredicts and keeps saturating statistics counters for performance runs.

## Interface
Parameters:
- BTB_ENTRIES, 16, number of BTB entries; power of two, 2..256
- PHT_ENTRIES, 64, number of PHT counters; power of two, 4..1024
- GHR_BITS, 4, global history length; used only with gshare enabled; must be ≤ log2(PHT_ENTRIES)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- fetch_pc  in  16  PC of the instruction in IF
- pred_bits  out  lc3b_brp_bits  {btb_hit, pht_taken} for fetch_pc
- pred_taken  out  1  btb_hit & pht_taken
- pred_target  out  16  BTB target; 16'h0000 when btb_hit=0
- upd_valid  in  1  a branch resolved this cycle
- upd_pc  in  16  PC of the resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  16  actual target
- upd_brp  in  lc3b_brp_bits  prediction carried with the branch
- upd_pred_target  in  16  predicted target carried with the branch
- mispredict  out  1  combinational redirect request
- br_count  out  16  resolved branches, saturating
- mp_count  out  16  mispredicts, saturating

## Operation
- Let B = log2(BTB_ENTRIES) and P = log2(PHT_ENTRIES). Bit 0 of every PC is ignored (word aligned).
- BTB index = pc[B:1]. BTB tag = pc[15:B+1]. Each entry holds {valid, tag, target}.
- btb_hit = valid & tag match.
- PHT index (base) = pc[P:1].
- pht_taken = counter[1].
- Counter encoding: 00 strongly not taken (SNT), 01 weakly not taken (WNT), 10 weakly taken (WT), 11 strongly taken (ST).
- Reads are combinational from registers. There is no bypass: if an update and a read target the same entry in the same cycle, the read returns the pre-edge value.
- On upd_valid, at the rising edge:
  - The PHT counter at upd_pc's index increments if upd_taken, else decrements. It saturates at 11 and 00.
  - If upd_taken, the BTB entry is written: valid=1, tag, target=upd_target. This replaces any occupant.
  - If not taken, the BTB is untouched and hit entries remain valid.
- mispredict = upd_valid & ((upd_brp.btb_hit & upd_brp.pht_taken) != upd_taken | (upd_taken & predicted-taken & upd_pred_target != upd_target)).
- br_count increments on upd_valid. mp_count increments on mispredict. Both hold at 16'hFFFF.
- Reset (asynchronous, any time, including mid-update):
  - All BTB valid bits clear.
  - Every PHT counter = 01 (WNT).
  - Counters = 0.
  - Resulting outputs: pred_bits=2'b00, pred_taken=0, pred_target=0.
  - mispredict depends only on its inputs.

## Timing
- Prediction latency 0: outputs follow fetch_pc within the same cycle.
- An update takes effect at the edge where upd_valid=1 and is visible to fetch_pc from the next cycle.
- mispredict is valid in the same cycle as upd_valid and is not registered.
- Back-to-back updates to the same index on consecutive cycles each apply. Two ST→decrements in a row give ST→WT→WNT.

## Configuration
- LC3B_BPRED_GSHARE_EN defined:
  - A GHR_BITS global history register is added, reset to 0.
  - PHT index = pc[P:1] XOR zero-extended GHR, for both predict and update.
  - On upd_valid, GHR shifts left and takes upd_taken into bit 0. This happens at the same edge as the PHT write.
  - The update index uses the pre-shift GHR. History is non-speculative only.
- LC3B_BPRED_GSHARE_EN undefined: no GHR exists; the PHT index is the pc bits alone.

## Structure
- Shared package lc3b_types holds:
  - lc3b_brp_bits (existing)
  - new typedef lc3b_pht_ctr = logic [1:0]
  - constants PHT_SNT=2'b00, PHT_WNT=2'b01, PHT_WT=2'b10, PHT_ST=2'b11
- Sub-module lc3b_btb: parametrised tag/target/valid array with combinational read, synchronous write and asynchronous clear.
- The PHT, GHR, mispredict logic and counters stay in lc3b_bpred.

## Test plan
- Reset: after reset, fetch_pc=16'h3000 → pred_bits=00, pred_target=0, br_count=0, mp_count=0.
- Training:
  - Update pc=16'h3000, taken, target=16'h3040, upd_brp=00 → mispredict=1.
  - Next cycle: fetch 16'h3000 → btb_hit=1, pht_taken=1 (WNT→WT), pred_target=16'h3040.
  - After that, mp_count=1.
- Saturation/hysteresis: four taken updates to 16'h3000, then one not-taken → pht_taken stays 1 (ST→WT). A second not-taken → 0.
- Aliasing: with BTB_ENTRIES=16, taken to 16'h3000 then taken to 16'h3020 (same index, other tag) → fetch 16'h3000 misses, fetch 16'h3020 hits.
- Target mismatch: upd taken, upd_brp=11, upd_pred_target=16'h3040, upd_target=16'h3080 → mispredict=1 and the BTB target is rewritten to 16'h3080.
- Async reset during upd_valid=1, plus counter saturation:
  - Asserting reset mid-cycle during upd_valid=1 clears state immediately; no update is applied.
  - Preloaded br_count=16'hFFFF plus one update stays at 16'hFFFF.
